eth_rx_udp_filter: RTL



---
 rtl/eth_rx_udp_filter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/eth_rx_udp_filter.sv
// Ethernet/IPv4/UDP receive filter: parses the headers, drops frames that are not
// addressed to this adapter, and forwards the UDP payload realigned to lane 0.
module eth_rx_udp_filter #(
  parameter logic [47:0] LOCAL_MAC    = 48'h0011_2233_4455,
  parameter logic [31:0] LOCAL_IP     = 32'hc0a8_0a01,
  parameter logic [15:0] UDP_PORT_MIN = 16'h3000,
  parameter logic [15:0] UDP_PORT_MAX = 16'h4fff
) (
  input  logic        eth_clk,
  input  logic        sys_rst,
  input  logic        eth_rx_tvalid,
  input  logic [63:0] eth_rx_tdata,
  input  logic [7:0]  eth_rx_tkeep,
  input  logic        eth_rx_tlast,
  input  logic        eth_rx_tuser,
  output logic        udp_rx_tvalid,
  output logic [63:0] udp_rx_tdata,
  output logic [7:0]  udp_rx_tkeep,
  output logic        udp_rx_tlast,
  output logic        udp_rx_tuser,
  output logic [31:0] udp_rx_src_ip,
  output logic [15:0] udp_rx_src_port,
  output logic [15:0] udp_rx_dst_port,
  output logic [15:0] rx_frame_cnt,
  output logic [15:0] rx_drop_cnt
);

  typedef enum logic [1:0] {S_HDR, S_PAY, S_FLUSH, S_DROP} state_t;

  state_t      state;
  logic [2:0]  beat_idx;
  logic [47:0] hold_data;
  logic [5:0]  hold_keep;
  logic        hold_user;
  logic [7:0]  b [8];
  logic [47:0] dst_mac;
  logic [15:0] dst_port;
  logic        hdr_ok;
  logic        hdr_fail;

  function automatic logic [63:0] keep_mask(input logic [63:0] d, input logic [7:0] k);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = d[8*i +: 8] & {8{k[i]}};
    return m;
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) b[i] = eth_rx_tdata[8*i +: 8];
  end

  assign dst_mac  = {b[0], b[1], b[2], b[3], b[4], b[5]};
  assign dst_port = {b[4], b[5]};

  // One field group per header beat; dst IP straddles beats 3 and 4.
  always_comb begin
    hdr_ok = 1'b1;
    case (beat_idx)
      3'd0: hdr_ok = (dst_mac == LOCAL_MAC) || (dst_mac == 48'hffff_ffff_ffff);
      3'd1: hdr_ok = ({b[4], b[5]} == 16'h0800) && (b[6] == 8'h45);
      3'd2: hdr_ok = (b[7] == 8'h11);
      3'd3: hdr_ok = ({b[6], b[7]} == LOCAL_IP[31:16]);
      3'd4: hdr_ok = ({b[0], b[1]} == LOCAL_IP[15:0]) &&
                     (dst_port >= UDP_PORT_MIN) && (dst_port <= UDP_PORT_MAX);
      3'd5: hdr_ok = !eth_rx_tlast || eth_rx_tkeep[2];
      default: hdr_ok = 1'b1;
    endcase
    hdr_fail = !hdr_ok || (eth_rx_tlast && (eth_rx_tuser || beat_idx != 3'd5));
  end

  always_ff @(posedge eth_clk) begin
    if (sys_rst) begin
      state           <= S_HDR;
      beat_idx        <= '0;
      hold_data       <= '0;
      hold_keep       <= '0;
      hold_user       <= 1'b0;
      udp_rx_tvalid   <= 1'b0;
      udp_rx_tdata    <= '0;
      udp_rx_tkeep    <= '0;
      udp_rx_tlast    <= 1'b0;
      udp_rx_tuser    <= 1'b0;
      udp_rx_src_ip   <= '0;
      udp_rx_src_port <= '0;
      udp_rx_dst_port <= '0;
      rx_frame_cnt    <= '0;
      rx_drop_cnt     <= '0;
    end else begin
      udp_rx_tvalid <= 1'b0;
      udp_rx_tlast  <= 1'b0;
      udp_rx_tuser  <= 1'b0;

      // The remainder beat goes out regardless of tvalid; header parsing of the
      // next frame may overlap it below.
      if (state == S_FLUSH) begin
        udp_rx_tvalid <= 1'b1;
        udp_rx_tdata  <= keep_mask({16'h0, hold_data}, {2'b00, hold_keep});
        udp_rx_tkeep  <= {2'b00, hold_keep};
        udp_rx_tlast  <= 1'b1;
        udp_rx_tuser  <= hold_user;
        rx_frame_cnt  <= rx_frame_cnt + 16'd1;
        state         <= S_HDR;
      end

      if (eth_rx_tvalid) begin
        case (state)
          S_HDR, S_FLUSH: begin
            if (beat_idx == 3'd3) udp_rx_src_ip <= {b[2], b[3], b[4], b[5]};
            if (beat_idx == 3'd4) begin
              udp_rx_src_port <= {b[2], b[3]};
              udp_rx_dst_port <= dst_port;
            end
            if (hdr_fail) begin
              beat_idx <= '0;
              if (eth_rx_tlast) begin
                rx_drop_cnt <= rx_drop_cnt + 16'd1;
                state       <= S_HDR;
              end else begin
                state <= S_DROP;
              end
            end else if (beat_idx == 3'd5) begin
              beat_idx <= '0;
              if (eth_rx_tlast) begin
                udp_rx_tvalid <= 1'b1;
                udp_rx_tdata  <= keep_mask({16'h0, eth_rx_tdata[63:16]}, {2'b00, eth_rx_tkeep[7:2]});
                udp_rx_tkeep  <= {2'b00, eth_rx_tkeep[7:2]};
                udp_rx_tlast  <= 1'b1;
                rx_frame_cnt  <= rx_frame_cnt + 16'd1;
                state         <= S_HDR;
              end else begin
                hold_data <= eth_rx_tdata[63:16];
                state     <= S_PAY;
              end
            end else begin
              beat_idx <= beat_idx + 3'd1;
            end
          end
          S_PAY: begin
            udp_rx_tvalid <= 1'b1;
            hold_data     <= eth_rx_tdata[63:16];
            hold_keep     <= eth_rx_tkeep[7:2];
            hold_user     <= eth_rx_tuser;
            if (eth_rx_tlast && !eth_rx_tkeep[2]) begin
              udp_rx_tdata <= keep_mask({eth_rx_tdata[15:0], hold_data}, {eth_rx_tkeep[1:0], 6'h3f});
              udp_rx_tkeep <= {eth_rx_tkeep[1:0], 6'h3f};
              udp_rx_tlast <= 1'b1;
              udp_rx_tuser <= eth_rx_tuser;
              rx_frame_cnt <= rx_frame_cnt + 16'd1;
              state        <= S_HDR;
            end else begin
              udp_rx_tdata <= {eth_rx_tdata[15:0], hold_data};
              udp_rx_tkeep <= 8'hff;
              if (eth_rx_tlast) state <= S_FLUSH;
            end
          end
          S_DROP: begin
            if (eth_rx_tlast) begin
              rx_drop_cnt <= rx_drop_cnt + 16'd1;
              state       <= S_HDR;
            end
          end
          default: state <= S_HDR;
        endcase
      end
    end
  end

endmodule
